spmv_row_reduce: RTL

Downstream consumer of the merge core's store-queue stream. Accepts the sorted (row index, partial product) pairs, sums consecutive entries with equal row index into one result per row, and packs the reduced results PACK-per-word into write words with a word address. Sits between the merge core's `stq_valid/stq_data/stq_ready` handshake and the DRAM store port.

---
 rtl/spmv_reduce_pkg.sv | 23 ++
 rtl/reduce_packer.sv | 118 +++++++++++
 rtl/spmv_row_reduce.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/spmv_reduce_pkg.sv
// Shared types for the SpMV row-reduce stage: entry layout, FSM states and widths.
// Consumers: reduce_packer, spmv_row_reduce (optional feature macro: SPMV_REDUCE_ORDER_CHECK_EN).
package spmv_reduce_pkg;

    localparam int BITS_ROW_IDX   = 32;
    localparam int DATA_PRECISION = 32;
    localparam int ENTRY_W        = BITS_ROW_IDX + DATA_PRECISION;

    typedef struct packed {
        logic [BITS_ROW_IDX-1:0]   row_idx;
        logic [DATA_PRECISION-1:0] value;
    } reduce_entry_t;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RUN        = 3'd1,
        S_FLUSH_ACC  = 3'd2,
        S_FLUSH_PACK = 3'd3,
        S_DRAIN      = 3'd4,
        S_DONE       = 3'd5
    } state_t;

endpackage

// File: rtl/reduce_packer.sv
// Packs reduced (row, value) entries PACK-per-word and owns the output word register
// and its valid/ready handshake, plus the lane and word counters.
module reduce_packer
    import spmv_reduce_pkg::*;
#(
    parameter int E      = ENTRY_W,
    parameter int PACK   = 4,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clear,
    input  logic                i_push,
    input  logic [E-1:0]        i_push_entry,
    input  logic                i_push_last,
    input  logic                i_flush,
    input  logic                i_out_ready,
    output logic                o_can_load,
    output logic                o_last_lane,
    output logic                o_out_valid,
    output logic [PACK*E-1:0]   o_out_data,
    output logic [PACK-1:0]     o_out_mask,
    output logic [ADDR_W-1:0]   o_out_addr,
    output logic                o_out_last
);

    localparam int LC_W = $clog2(PACK);

    logic [PACK-1:0][E-1:0] r_lanes;
    logic [LC_W-1:0]        r_lane_ctr;
    logic [ADDR_W-1:0]      r_word_ctr;
    logic                   r_out_valid;
    logic [PACK*E-1:0]      r_out_data;
    logic [PACK-1:0]        r_out_mask;
    logic [ADDR_W-1:0]      r_out_addr;
    logic                   r_out_last;

    logic [PACK*E-1:0]      w_full_word;
    logic [PACK*E-1:0]      w_part_word;
    logic [PACK-1:0]        w_part_mask;

    // The output register may be reloaded in the same cycle its current word is taken.
    assign o_can_load  = !r_out_valid || i_out_ready;
    assign o_last_lane = (r_lane_ctr == LC_W'(PACK-1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_full_word = '0;
        w_part_word = '0;
        w_part_mask = '0;
        for (int k = 0; k < PACK; k++) begin
            if (LC_W'(k) < r_lane_ctr) begin
                w_part_word[k*E +: E] = r_lanes[k];
                w_part_mask[k]        = 1'b1;
            end
            if (k < PACK-1) begin
                w_full_word[k*E +: E] = r_lanes[k];
            end
        end
        w_full_word[(PACK-1)*E +: E] = i_push_entry;
    end

    // NOTE: state uses non-blocking assignments; the lane array is small, so it is reset too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lanes     <= '0;
            r_lane_ctr  <= '0;
            r_word_ctr  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_mask  <= '0;
            r_out_addr  <= '0;
            r_out_last  <= 1'b0;
        end else if (i_clear) begin
            r_lanes     <= '0;
            r_lane_ctr  <= '0;
            r_word_ctr  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_mask  <= '0;
            r_out_addr  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (i_push) begin
                if (o_last_lane) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_full_word;
                    r_out_mask  <= '1;
                    r_out_addr  <= r_word_ctr;
                    r_out_last  <= i_push_last;
                    r_word_ctr  <= r_word_ctr + ADDR_W'(1);
                    r_lane_ctr  <= '0;
                end else begin
                    r_lanes[r_lane_ctr] <= i_push_entry;
                    r_lane_ctr          <= r_lane_ctr + LC_W'(1);
                end
            end else if (i_flush) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_part_word;
                r_out_mask  <= w_part_mask;
                r_out_addr  <= r_word_ctr;
                r_out_last  <= 1'b1;
                r_word_ctr  <= r_word_ctr + ADDR_W'(1);
                r_lane_ctr  <= '0;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_mask  = r_out_mask;
    assign o_out_addr  = r_out_addr;
    assign o_out_last  = r_out_last;

endmodule

// File: rtl/spmv_row_reduce.sv
// Sums consecutive equal-row partial products from the merge core and hands one entry per
// row to reduce_packer. `define SPMV_REDUCE_ORDER_CHECK_EN builds the sticky row-order check.
module spmv_row_reduce
    import spmv_reduce_pkg::*;
#(
    parameter int ROW_IDX_W = BITS_ROW_IDX,
    parameter int VAL_W     = DATA_PRECISION,
    parameter int PACK      = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ROW_IDX_W+VAL_W-1:0]        in_data,
    input  logic                              in_done,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [PACK*(ROW_IDX_W+VAL_W)-1:0] out_data,
    output logic [PACK-1:0]                   out_mask,
    output logic [ADDR_W-1:0]                 out_addr,
    output logic                              out_last,
    output logic                              done,
    output logic                              err
);

    localparam int E = ROW_IDX_W + VAL_W;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_acc_valid;
    logic [ROW_IDX_W-1:0]   r_acc_row;
    logic [VAL_W-1:0]       r_acc_val;

    logic [ROW_IDX_W-1:0]   w_row;
    logic [VAL_W-1:0]       w_val;
    logic                   w_fire;
    logic                   w_same_row;
    logic                   w_clear;
    logic                   w_push;
    logic                   w_push_last;
    logic                   w_flush;
    logic                   w_acc_drop;
    logic                   w_can_load;
    logic                   w_last_lane;

    assign w_row      = in_data[E-1 -: ROW_IDX_W];
    assign w_val      = in_data[VAL_W-1:0];
    assign in_ready   = (r_state == S_RUN) && w_can_load;
    assign w_fire     = in_valid && in_ready;
    assign w_same_row = r_acc_valid && (w_row == r_acc_row);
    assign done       = (r_state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_push       = 1'b0;
        w_push_last  = 1'b0;
        w_flush      = 1'b0;
        w_acc_drop   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_clear      = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                // A beat arriving with in_done is consumed before the flush starts.
                if (w_fire) begin
                    w_push = r_acc_valid && !w_same_row;
                end else if (in_done) begin
                    w_state_next = S_FLUSH_ACC;
                end
            end
            S_FLUSH_ACC: begin
                if (!r_acc_valid) begin
                    w_state_next = S_FLUSH_PACK;
                end else if (w_can_load) begin
                    w_push      = 1'b1;
                    w_acc_drop  = 1'b1;
                    w_push_last = w_last_lane;
                    w_state_next = w_last_lane ? S_DRAIN : S_FLUSH_PACK;
                end
            end
            S_FLUSH_PACK: begin
                if (w_can_load) begin
                    w_flush      = 1'b1;
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_valid && out_ready && out_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!enable) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_valid <= 1'b0;
            r_acc_row   <= '0;
            r_acc_val   <= '0;
        end else if (w_clear) begin
            r_acc_valid <= 1'b0;
            r_acc_row   <= '0;
            r_acc_val   <= '0;
        end else if (w_fire) begin
            if (w_same_row) begin
                r_acc_val <= r_acc_val + w_val;
            end else begin
                r_acc_valid <= 1'b1;
                r_acc_row   <= w_row;
                r_acc_val   <= w_val;
            end
        end else if (w_acc_drop) begin
            r_acc_valid <= 1'b0;
        end
    end

`ifdef SPMV_REDUCE_ORDER_CHECK_EN
    logic r_err;

    // Cleared on the way back into IDLE so each stream starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state != S_IDLE && w_state_next == S_IDLE) begin
            r_err <= 1'b0;
        end else if (w_fire && r_acc_valid && (w_row < r_acc_row)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    reduce_packer #(
        .E      (E),
        .PACK   (PACK),
        .ADDR_W (ADDR_W)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_push       (w_push),
        .i_push_entry ({r_acc_row, r_acc_val}),
        .i_push_last  (w_push_last),
        .i_flush      (w_flush),
        .i_out_ready  (out_ready),
        .o_can_load   (w_can_load),
        .o_last_lane  (w_last_lane),
        .o_out_valid  (out_valid),
        .o_out_data   (out_data),
        .o_out_mask   (out_mask),
        .o_out_addr   (out_addr),
        .o_out_last   (out_last)
    );

endmodule
